// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder side of the pipeline data-memory interface. Each load or store
//   takes a fixed LATENCY cycles. Busy stalls the pipeline while the access
//   is in flight, and Ready pulses for one cycle when it completes.
//
// Parameters
//   SIZE    : storage size in bytes (power of two), organised as SIZE/4 words
//   LATENCY : cycles Busy stays high per access (1..15)
//
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous, active-low reset
//   ReadEnable  : load request from the MEM stage
//   WriteEnable : store request from the MEM stage
//   Address     : byte address of the access
//   WriteData   : store data
//   ReadData    : registered load result, held until the next completion
//   Busy        : stall request to the pipeline
//   Ready       : one-cycle completion pulse
//   Error       : coincident with Ready, marks a rejected access
module data_memory_responder #(
  parameter int unsigned SIZE    = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Ready,
  output logic        Error
);

  localparam int unsigned WORDS     = SIZE / 4;
  localparam int unsigned AW        = $clog2(SIZE);
  localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);
  localparam bit          SINGLE    = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, wdata_reg;
  logic        re_reg, we_reg;
  logic        err_reg;
  logic [31:0] read_data_reg;
  logic        enter_done;

  logic [31:0] mem [WORDS];

  logic          req, in_idle;
  logic [31:0]   eff_addr, eff_wdata;
  logic          eff_re, eff_we, eff_err;
  logic [AW-3:0] eff_idx;

  assign req     = ReadEnable | WriteEnable;
  assign in_idle = (state_reg == S_IDLE);

  // With LATENCY=1 the edge that accepts a request is also the edge that
  // enters DONE. At that point the request is not latched yet, so the
  // commit and load paths look at the live inputs while in IDLE and at the
  // latched copy otherwise.
  assign eff_addr  = in_idle ? Address     : addr_reg;
  assign eff_wdata = in_idle ? WriteData   : wdata_reg;
  assign eff_re    = in_idle ? ReadEnable  : re_reg;
  assign eff_we    = in_idle ? WriteEnable : we_reg;
  assign eff_idx   = eff_addr[AW-1:2];

  // A rejected access is misaligned, out of range, or asks for a load and
  // a store at the same time.
  assign eff_err = (eff_addr[1:0] != 2'b00) |
                   (eff_addr >= 32'(SIZE)) |
                   (eff_re & eff_we);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_done = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (SINGLE) begin
            state_next = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        // The counter reaches zero on this edge.
        if (cnt_reg == 4'd1) begin
          state_next = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        // Inputs seen here belong to the request that was just serviced.
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      re_reg        <= 1'b0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      read_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (in_idle && req) begin
        addr_reg  <= Address;
        wdata_reg <= WriteData;
        re_reg    <= ReadEnable;
        we_reg    <= WriteEnable;
      end
      if (enter_done) begin
        err_reg <= eff_err;
        if (eff_err)
          read_data_reg <= 32'd0;
        else if (eff_re)
          read_data_reg <= mem[eff_idx];
      end
    end
  end

  // The storage array is never reset. Gating with reset keeps a store that
  // was interrupted by reset from committing on a later edge.
  always_ff @(posedge clock) begin
    if (enter_done && reset && eff_we && !eff_err)
      mem[eff_idx] <= eff_wdata;
  end

  assign ReadData = read_data_reg;
  assign Busy     = (in_idle & req) | (state_reg == S_WAIT);
  assign Ready    = (state_reg == S_DONE);
  assign Error    = (state_reg == S_DONE) & err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic        clk;
  logic        rst_n;

  // DUT with LATENCY=2
  logic        re2, we2;
  logic [31:0] addr2, wd2, rdata2;
  logic        busy2, rdy2, err2;

  // DUT with LATENCY=1
  logic        re1, we1;
  logic [31:0] addr1, wd1, rdata1;
  logic        busy1, rdy1, err1;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy1_count = 0;

  data_memory_responder #(.SIZE(4096), .LATENCY(2)) u2 (
    .clock(clk), .reset(rst_n),
    .ReadEnable(re2), .WriteEnable(we2), .Address(addr2), .WriteData(wd2),
    .ReadData(rdata2), .Busy(busy2), .Ready(rdy2), .Error(err2)
  );

  data_memory_responder #(.SIZE(4096), .LATENCY(1)) u1 (
    .clock(clk), .reset(rst_n),
    .ReadEnable(re1), .WriteEnable(we1), .Address(addr1), .WriteData(wd1),
    .ReadData(rdata1), .Busy(busy1), .Ready(rdy1), .Error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rdy1) rdy1_count++;

  // Present one request on the LATENCY=2 DUT, hold it like a stalled
  // pipeline until Ready, and return the result and cycles before Ready.
  task automatic access2(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic er, output int lat);
    re2 = re; we2 = we; addr2 = a; wd2 = d;
    lat = 0; rd = 32'd0; er = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy2) begin
        rd = rdata2; er = err2;
        break;
      end
      lat++;
      if (lat > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL access2_timeout addr=%h: no Ready after %0d cycles, required %0d", a, lat, 2);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    re2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic er; int lat;
    re2 = 0; we2 = 0; addr2 = 0; wd2 = 0;
    re1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdata2 !== 32'd0) begin n_bad++; $display("FAIL reset_rdata2 got=%h want=%h", rdata2, 32'd0); end
    n_cmp++; if ({busy2, rdy2, err2} !== 3'b000) begin n_bad++; $display("FAIL reset_flags2 got busy/rdy/err=%b want=000", {busy2, rdy2, err2}); end
    n_cmp++; if ({rdata1, busy1, rdy1, err1} !== 35'd0) begin n_bad++; $display("FAIL reset_u1 got rdata=%h flags=%b want 0", rdata1, {busy1, rdy1, err1}); end
    @(posedge clk); #1;
    // Known prior contents at 0x10.
    access2(1'b0, 1'b1, 32'h10, 32'h11111111, rd, er, lat);
    // Store DEADBEEF, abort with reset while it sits in WAIT.
    re2 = 0; we2 = 1; addr2 = 32'h10; wd2 = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst_n = 1'b0; we2 = 0;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2, err2} !== 3'b000) begin n_bad++; $display("FAIL reset_midwait_flags got=%b want=000", {busy2, rdy2, err2}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rdata2, busy2, rdy2} !== 34'd0) begin n_bad++; $display("FAIL reset_after_release got rdata=%h busy=%b rdy=%b want 0", rdata2, busy2, rdy2); end
    @(posedge clk); #1;
    access2(1'b1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h11111111) begin n_bad++; $display("FAIL reset_discard_store got=%h want=%h", rd, 32'h11111111); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL reset_load_latency got=%0d want=%0d", lat, 2); end
  endtask

  task automatic test_latency2_timing;
    // Store: cycles 0..2
    we2 = 1; re2 = 0; addr2 = 32'h20; wd2 = 32'h12345678;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2} !== 2'b10) begin n_bad++; $display("FAIL l2_store_c0 got busy/rdy=%b want=10", {busy2, rdy2}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2} !== 2'b10) begin n_bad++; $display("FAIL l2_store_c1 got busy/rdy=%b want=10", {busy2, rdy2}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2, err2} !== 3'b010) begin n_bad++; $display("FAIL l2_store_c2 got busy/rdy/err=%b want=010", {busy2, rdy2, err2}); end
    // Load accepted in cycle 3, right after DONE.
    @(posedge clk); #1;
    we2 = 0; re2 = 1; addr2 = 32'h20;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2} !== 2'b10) begin n_bad++; $display("FAIL l2_load_c3 got busy/rdy=%b want=10", {busy2, rdy2}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2} !== 2'b10) begin n_bad++; $display("FAIL l2_load_c4 got busy/rdy=%b want=10", {busy2, rdy2}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if ({busy2, rdy2, err2} !== 3'b010) begin n_bad++; $display("FAIL l2_load_c5 got busy/rdy/err=%b want=010", {busy2, rdy2, err2}); end
    n_cmp++; if (rdata2 !== 32'h12345678) begin n_bad++; $display("FAIL l2_load_data got=%h want=%h", rdata2, 32'h12345678); end
    @(posedge clk); #1;
    re2 = 0;
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if ({rdata2, rdy2} !== {32'h12345678, 1'b0}) begin n_bad++; $display("FAIL l2_hold_c%0d got rdata=%h rdy=%b want %h/0", c, rdata2, rdy2, 32'h12345678); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    access2(1'b1, 1'b0, 32'h22, 32'h0, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b1, 32'd0} || lat !== 2) begin n_bad++; $display("FAIL err_misaligned_load got err=%b rd=%h lat=%0d want 1/0/2", er, rd, lat); end
    access2(1'b1, 1'b0, 32'h1000, 32'h0, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b1, 32'd0} || lat !== 2) begin n_bad++; $display("FAIL err_range_load got err=%b rd=%h lat=%0d want 1/0/2", er, rd, lat); end
    // Rejected stores that would alias word 0x20.
    access2(1'b0, 1'b1, 32'h22, 32'hAAAAAAAA, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_misaligned_store got err=%b want 1", er); end
    access2(1'b0, 1'b1, 32'h1020, 32'hBBBBBBBB, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_range_store got err=%b want 1", er); end
    access2(1'b1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b0, 32'h12345678}) begin n_bad++; $display("FAIL err_array_unchanged got err=%b rd=%h want 0/%h", er, rd, 32'h12345678); end
  endtask

  task automatic test_both_enables;
    logic [31:0] rd; logic er; int lat;
    access2(1'b0, 1'b1, 32'h30, 32'h5A5A5A5A, rd, er, lat);
    access2(1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL both_en_error got err=%b rd=%h want 1/0", er, rd); end
    access2(1'b1, 1'b0, 32'h30, 32'h0, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b0, 32'h5A5A5A5A}) begin n_bad++; $display("FAIL both_en_no_write got err=%b rd=%h want 0/%h", er, rd, 32'h5A5A5A5A); end
  endtask

  task automatic test_drop_enable;
    logic [31:0] rd; logic er; int lat; bit seen;
    re2 = 0; we2 = 1; addr2 = 32'h40; wd2 = 32'h0BADF00D;
    @(posedge clk); #1;
    we2 = 0; addr2 = 32'h0; wd2 = 32'h0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rdy2) seen = 1;
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL drop_en_ready got no Ready want Ready"); end
    access2(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_cmp++; if ({er, rd} !== {1'b0, 32'h0BADF00D}) begin n_bad++; $display("FAIL drop_en_commit got err=%b rd=%h want 0/%h", er, rd, 32'h0BADF00D); end
  endtask

  task automatic test_latency1_stream;
    logic [31:0] exp_data;
    rdy1_count = 0;
    for (int k = 0; k < 8; k++) begin
      exp_data = 32'hA0000000 + 32'(k / 2) * 32'h01010101;
      addr1 = 32'h100 + 32'(k / 2) * 32'h4;
      we1 = (k % 2 == 0); re1 = (k % 2 == 1); wd1 = exp_data;
      @(negedge clk);
      n_cmp++; if ({busy1, rdy1} !== 2'b10) begin n_bad++; $display("FAIL l1_op%0d_accept got busy/rdy=%b want=10", k, {busy1, rdy1}); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({busy1, rdy1, err1} !== 3'b010) begin n_bad++; $display("FAIL l1_op%0d_done got busy/rdy/err=%b want=010", k, {busy1, rdy1, err1}); end
      if (k % 2 == 1) begin
        n_cmp++; if (rdata1 !== exp_data) begin n_bad++; $display("FAIL l1_op%0d_data got=%h want=%h", k, rdata1, exp_data); end
      end
      @(posedge clk); #1;
    end
    re1 = 0; we1 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rdy1_count !== 8) begin n_bad++; $display("FAIL l1_ready_count got=%0d want=%0d", rdy1_count, 8); end
  endtask

  initial begin
    test_reset();
    test_latency2_timing();
    test_errors();
    test_both_enables();
    test_drop_enable();
    test_latency1_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the pipeline's data-memory interface: services load/store requests issued by the CPU MEM stage with a fixed multi-cycle latency.
- Drives a Busy stall request back to the pipeline while an access is in flight.
- Contains the word-addressed data storage array.
- Replaces the single-cycle data memory wherever a slower backing store is modelled.

Parameters:
- SIZE, 4096, data memory size in bytes; SIZE/4 words; power of two.
- LATENCY, 2, cycles Busy stays high per access; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ReadEnable  input  1  load request from MEM stage
- WriteEnable  input  1  store request from MEM stage
- Address  input  32  byte address of the access
- WriteData  input  32  store data
- ReadData  output  32  load result, registered, held until the next completion
- Busy  output  1  stall request to the pipeline (PC, IF/ID, ID/EX, EX/MEM hold)
- Ready  output  1  one-cycle completion pulse
- Error  output  1  one-cycle flag, coincident with Ready, marks a rejected access

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, ReadData=0, Ready=0, Error=0.
  - Storage array is not cleared.
  - A pending access is discarded; a pending store is never committed.
- States:
  - IDLE: a request is present when ReadEnable|WriteEnable=1. At the clock edge, latch Address, WriteData and op, then go to WAIT (LATENCY>1) or DONE (LATENCY=1). No request: stay in IDLE.
  - WAIT: 4-bit counter is loaded with LATENCY-1 on accept and decrements each cycle. Go to DONE on the edge where the counter reaches 0, i.e. WAIT lasts LATENCY-1 cycles.
  - DONE: lasts exactly one cycle, Ready=1, then IDLE unconditionally. Inputs seen during DONE are ignored; they are the same stalled request, so it is never re-accepted.
- Busy:
  - Combinational: Busy = (IDLE & (ReadEnable|WriteEnable)) | WAIT.
  - Low in DONE, so the pipeline advances at the end of the DONE cycle.
  - For a request first presented in cycle 0: Busy is high in cycles 0..LATENCY-1, Ready in cycle LATENCY.
- Store commit: the array word Address[log2(SIZE)-1:2] is written on the edge entering DONE.
- Load: ReadData is loaded on the edge entering DONE. ReadData keeps its value outside DONE and changes only when entering DONE.
- Error conditions, checked on the latched request:
  - Address[1:0]!=0 (misaligned),
  - Address>=SIZE (out of range),
  - ReadEnable&WriteEnable both 1.
  - Any of these: full latency still elapses, Error=1 with Ready, no array write, ReadData loaded with 0.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following DONE. Minimum spacing between accepts is LATENCY+1 cycles.
- Read-after-write to the same address returns the newly written data, since the commit precedes the next accept.
- Deasserting an enable while in WAIT has no effect; the latched request completes.

Test Plan:
- Reset low mid-WAIT of a store of 0xDEADBEEF to 0x10, then a load from 0x10 after release → load returns the prior contents, not 0xDEADBEEF. Immediately after reset: ReadData=0, Busy=0, Ready=0.
- LATENCY=2: store 0x12345678 to 0x20 in cycle 0 → Busy=1 in cycles 0-1, Ready=1 in cycle 2. Load from 0x20 in cycle 3 → Busy in cycles 3-4, Ready in cycle 5, ReadData=0x12345678 stable through cycle 8.
- LATENCY=1: continuous alternating store/load stream → Ready pulses every 2 cycles, no request is accepted twice, each load returns the data of the preceding store.
- Load from 0x22 (misaligned), then load from 0x1000 with SIZE=4096 (out of range) → each gives Ready=1 and Error=1 after LATENCY cycles with ReadData=0; array unchanged.
- ReadEnable=WriteEnable=1 with Address=0x30, WriteData=0xFFFFFFFF → Error=1, and a subsequent load from 0x30 returns the old value.
- Store to 0x40, then drop WriteEnable during WAIT → the store still commits; a load from 0x40 returns the stored value.
